// File: rtl/wb_stage_pipelined.sv
// wb_stage_pipelined
// MIPS write-back stage: MEM/WB pipeline register (stall/flush), retiring
// instruction decode into GRF write controls, sub-word load extraction,
// link-address generation, and a retired-instruction counter.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in, instr_in, judge_in, pc_in, alu_result_in, dm_data_in,
//   write_reg_in                     : fields arriving from the MEM stage
//   stall, flush                     : pipeline register control (flush wins)
//   grf_a3, grf_we, grf_wd           : GRF write port
//   wb_valid, wb_pc                  : registered view of the retiring instr
//   illegal_instr                    : retiring instr outside the decoded set
//   retire_count                     : count of retired valid instructions
//
// Register handshake: there is no backpressure output. Each rising edge
// either loads a bubble (flush), holds (stall), or accepts the MEM fields.
// An instruction retires on the edge that replaces it while valid.
module wb_stage_pipelined #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic              judge_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] dm_data_in,
  input  logic [REG_AW-1:0] write_reg_in,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] grf_a3,
  output logic              grf_we,
  output logic [DATA_W-1:0] grf_wd,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_pc,
  output logic              illegal_instr,
  output logic [CNT_W-1:0]  retire_count
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_BLEZALS = 6'h18;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  // MEM/WB pipeline register
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              judge_q, judge_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] dm_q, dm_d;
  logic [REG_AW-1:0] wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              replace;

  // The current occupant leaves whenever the register is not held; a flush
  // overrides stall, so the leaving instruction still counts as retired.
  assign replace = flush | ~stall;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    judge_d = judge_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    dm_d    = dm_q;
    wr_d    = wr_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
      judge_d = 1'b0;
      pc_d    = '0;
      alu_d   = '0;
      dm_d    = '0;
      wr_d    = '0;
    end else if (!stall) begin
      valid_d = valid_in;
      instr_d = instr_in;
      judge_d = judge_in;
      pc_d    = pc_in;
      alu_d   = alu_result_in;
      dm_d    = dm_data_in;
      wr_d    = write_reg_in;
    end
    cnt_d = cnt_q + CNT_W'(valid_q & replace);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      judge_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      dm_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      judge_q <= judge_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      dm_q    <= dm_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decode of the retiring instruction
  logic [5:0] op;
  logic [5:0] funct;
  logic [1:0] sel;
  logic       dec_we;
  logic       known;

  assign op    = instr_q[31:26];
  assign funct = instr_q[5:0];

  always_comb begin
    sel    = SEL_ALU;
    dec_we = 1'b0;
    known  = 1'b1;
    case (op)
      OP_SPECIAL: begin
        // Only the all-zero word is a nop; other shifts are not supported.
        if (instr_q != 32'h0) begin
          case (funct)
            FN_ADDU, FN_SUBU: dec_we = 1'b1;
            FN_JALR: begin
              sel    = SEL_LINK;
              dec_we = 1'b1;
            end
            FN_JR:   ;
            default: known = 1'b0;
          endcase
        end
      end
      OP_ORI, OP_LUI: dec_we = 1'b1;
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        sel    = SEL_LOAD;
        dec_we = 1'b1;
      end
      OP_JAL: begin
        sel    = SEL_LINK;
        dec_we = 1'b1;
      end
      OP_BLEZALS: begin
        sel    = SEL_LINK;
        dec_we = judge_q;
      end
      OP_BEQ, OP_SW, OP_SB, OP_SH, OP_J: ;
      default: known = 1'b0;
    endcase
  end

  // Sub-word load extraction, little-endian lanes within the word
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_val;

  always_comb begin
    case (alu_q[1:0])
      2'd0:    ld_byte = dm_q[7:0];
      2'd1:    ld_byte = dm_q[15:8];
      2'd2:    ld_byte = dm_q[23:16];
      default: ld_byte = dm_q[31:24];
    endcase
    ld_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
    case (op)
      OP_LB:   ld_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {{(DATA_W-8){1'b0}}, ld_byte};
      OP_LH:   ld_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_val = dm_q;
    endcase
  end

  always_comb begin
    case (sel)
      SEL_LOAD: grf_wd = ld_val;
      SEL_LINK: grf_wd = pc_q + DATA_W'(LINK_OFFSET);
      default:  grf_wd = alu_q;
    endcase
  end

  assign grf_a3        = wr_q;
  assign grf_we        = valid_q & dec_we & (wr_q != '0);
  assign wb_valid      = valid_q;
  assign wb_pc         = pc_q;
  assign illegal_instr = valid_q & ~known;
  assign retire_count  = cnt_q;

endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
Parametrised write-back stage for the 5-stage MIPS pipeline. It contains the MEM/WB pipeline register, with stall and flush. It decodes the retiring instruction into GRF write controls, extracts and extends sub-word load data, and produces the link address. It also exports a registered forwarding view and a retired-instruction counter. It sits between the data-memory stage and the GRF write port.

Parameters:
DATA_W, 32, datapath width for ALU result, memory data, PC and write data
REG_AW, 5, GRF address width
LINK_OFFSET, 8, value added to the captured PC to form the link address (delay-slot aware)
CNT_W, 32, width of retire counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
valid_in  in  1  MEM stage holds a real instruction
instr_in  in  32  MIPS instruction word from MEM stage
judge_in  in  1  condition result for conditional-link (blezals)
pc_in  in  DATA_W  PC of the instruction
alu_result_in  in  DATA_W  ALU result / memory byte address
dm_data_in  in  DATA_W  raw aligned word read from DM
write_reg_in  in  REG_AW  destination register number
stall  in  1  hold MEM/WB register
flush  in  1  replace incoming instruction with bubble
grf_a3  out  REG_AW  GRF write address
grf_we  out  1  GRF write enable
grf_wd  out  DATA_W  GRF write data
wb_valid  out  1  register holds a real instruction
wb_pc  out  DATA_W  PC of retiring instruction
illegal_instr  out  1  retiring instruction not in decoded set
retire_count  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset (reset=0, async): pipeline register becomes a bubble (valid=0, instr=0, all data 0); retire_count=0. All outputs read 0 while reset is held and until the first capture.
- Capture on posedge clk:
  - flush=1: load a bubble. Flush wins over stall.
  - else stall=1: hold all contents; retire_count does not increment.
  - else: load all *_in fields; valid=valid_in.
- Outputs are combinational from register contents, so latency is 1 cycle from MEM inputs to GRF write.
- Decode of registered instr, giving sel (0=ALU, 1=load, 2=link) and we:
  - ori, lui, addu, subu: sel 0, we 1.
  - lw, lb, lbu, lh, lhu: sel 1, we 1.
  - jal: sel 2, we 1.
  - jalr (funct 001001): sel 2, we 1.
  - blezals (op 011000): sel 2, we=judge.
  - beq, sw, sb, sh, j, jr, nop (all-zero word): we 0.
  - Any other opcode/funct: we 0, illegal_instr=1 (qualified by valid).
- grf_we = valid & decoded_we & (grf_a3 != 0). Writes to $0 are suppressed via WE; the data is not zeroed.
- grf_a3 = registered write_reg.
- Load extension uses addr = registered alu_result[1:0], little-endian:
  - lw: full word.
  - lb/lbu: byte at addr[1:0], sign-/zero-extended to DATA_W.
  - lh/lhu: half at addr[1] (addr[0] ignored), sign-/zero-extended.
- Link value = registered pc + LINK_OFFSET, modulo 2^DATA_W.
- retire_count increments by 1 on each posedge where the register holds valid=1 and is being replaced (not stalled). Wraps modulo 2^CNT_W. A flush does not cancel the retirement of the instruction leaving.
- While stall is held, the same instruction presents grf_we for multiple cycles. GRF rewrites are idempotent, so this is legal.
- Reset asserted mid-stream drops the in-flight instruction with no write.

Test Plan:
- Reset then ori: reset low 3 cycles, release; present ori $8 with alu=0x0000_1234, valid=1 → next cycle grf_we=1, grf_a3=8, grf_wd=0x1234; retire_count becomes 1 one cycle later.
- Loads: dm_data=0x80FF_7F01. lb with addr=2 → 0xFFFF_FFFF. lbu with addr=3 → 0x0000_0080. lh with addr=2 → 0xFFFF_80FF. lhu with addr=0 → 0x0000_7F01.
- Link: jal with pc=0x0000_3000, a3=31 → grf_wd=0x0000_3008, we=1. blezals with judge=0 → we=0. Same with judge=1 → we=1, wd=pc+8.
- $0 and non-writers: addu with a3=0 → we=0. sw, beq, j → we=0. Unknown opcode 0x3F → we=0 and illegal_instr=1.
- Stall/flush: stall=1 for 3 cycles holding addu $9 → outputs unchanged and retire_count frozen. stall=1 and flush=1 in the same cycle → bubble loaded, wb_valid=0.
- Async reset mid-stream: pulse reset low between clock edges while lw is in the register → outputs go 0 immediately and retire_count=0 with no clock edge. Also check that retire_count with CNT_W=4 wraps 15→0.
